// File: rtl/audio_pwm_out.sv
// audio_pwm_out: samples the summed piano waveform once per 256-clock PWM period,
// scales it by an attack/release envelope gain and drives a single-bit PWM pin.
`default_nettype none

module audio_pwm_out #(
  parameter int RAMP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wave,
  input  logic [7:0] keys,
  output logic       pwm_out,
  output logic       sample_tick,
  output logic [4:0] gain,
  output logic       active
);

  localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(RAMP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        duty_q, duty_d;
  logic              pwm_q, pwm_d;
  logic [4:0]        gain_q, gain_d;
  logic [RC_W-1:0]   rc_q, rc_d;

  logic              boundary;
  logic              key_active;
  logic              rc_last;
  logic signed [11:0] wave_s;
  logic signed [11:0] gain_s;
  logic signed [11:0] prod;
  logic [7:0]        duty_new;

  assign boundary   = (cnt_q == 8'd255);
  assign key_active = |keys;
  assign rc_last    = (rc_q == RC_MAX);

  // Product range [-2048,2032] fits 12 signed bits exactly; the floor shift
  // lands in [-128,127], so flipping the sign bit re-biases it to 0..255.
  assign wave_s   = $signed({4'b0000, wave}) - 12'sd128;
  assign gain_s   = $signed({7'b0000000, gain_q});
  assign prod     = wave_s * gain_s;
  assign duty_new = 8'(prod >>> 4) ^ 8'h80;

  always_comb begin
    cnt_d   = cnt_q + 8'd1;
    pwm_d   = (cnt_q < duty_q);
    duty_d  = duty_q;
    gain_d  = gain_q;
    rc_d    = rc_q;
    state_d = state_q;
    if (boundary) begin
      duty_d = duty_new;
      case (state_q)
        IDLE: begin
          gain_d = 5'd0;
          if (key_active) begin
            state_d = RAMP_UP;
            rc_d    = '0;
          end
        end
        RAMP_UP: begin
          if (!key_active) begin
            state_d = RAMP_DOWN;
            rc_d    = '0;
          end else if (rc_last) begin
            rc_d   = '0;
            gain_d = gain_q + 5'd1;
            if (gain_q >= 5'd15) begin
              gain_d  = 5'd16;
              state_d = PLAY;
            end
          end else begin
            rc_d = rc_q + RC_W'(1);
          end
        end
        PLAY: begin
          gain_d = 5'd16;
          if (!key_active) begin
            state_d = RAMP_DOWN;
            rc_d    = '0;
          end
        end
        RAMP_DOWN: begin
          if (key_active) begin
            state_d = RAMP_UP;
            rc_d    = '0;
          end else if (gain_q == 5'd0) begin
            // Released before the first attack step: nothing left to ramp.
            state_d = IDLE;
            rc_d    = '0;
          end else if (rc_last) begin
            rc_d   = '0;
            gain_d = gain_q - 5'd1;
            if (gain_q == 5'd1) state_d = IDLE;
          end else begin
            rc_d = rc_q + RC_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          gain_d  = 5'd0;
          rc_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      duty_q  <= 8'd128;
      pwm_q   <= 1'b0;
      gain_q  <= 5'd0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      gain_q  <= gain_d;
      rc_q    <= rc_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign sample_tick = boundary;
  assign gain        = gain_q;
  assign active      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out: directed checks of reset, attack, release, duty rounding,
// envelope reversal and mid-period input changes for audio_pwm_out.
`default_nettype none

module tb_audio_pwm_out;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wave = 8'd128;
  logic [7:0] keys = 8'd0;
  logic       pwm_out;
  logic       sample_tick;
  logic [4:0] gain;
  logic       active;

  int checks = 0;
  int failures = 0;
  int b = 0;

  audio_pwm_out #(.RAMP_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wave        (wave),
    .keys        (keys),
    .pwm_out     (pwm_out),
    .sample_tick (sample_tick),
    .gain        (gain),
    .active      (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Leaves time just after the next boundary edge.
  task automatic step_boundary();
    int n = 0;
    while (sample_tick !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("tick_found", int'(sample_tick), 1);
    @(posedge clk); #1;
    b++;
  endtask

  task automatic step_to(input int target);
    while (b < target) step_boundary();
  endtask

  // Starts just after a boundary edge, counts pwm high over one full period,
  // ends just after the following boundary edge.
  task automatic measure(input int chg_at, input logic [7:0] new_wave,
                         input logic [7:0] new_keys, output int hi, output int ticks);
    hi = 0;
    ticks = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      hi += int'(pwm_out);
      ticks += int'(sample_tick);
      if (i == chg_at) begin
        wave = new_wave;
        keys = new_keys;
      end
    end
    b++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int hi;
    int ticks;

    #1;
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_gain", int'(gain), 0);
    check("rst_active", int'(active), 0);
    check("rst_tick", int'(sample_tick), 0);

    #20;
    @(negedge clk) rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    check("idle_pwm_cnt100", int'(pwm_out), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_pwm", int'(pwm_out), 0);
    check("midrst_gain", int'(gain), 0);
    check("midrst_active", int'(active), 0);
    check("midrst_tick", int'(sample_tick), 0);

    @(negedge clk) rst_n = 1'b1;
    n = 0;
    while (sample_tick !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_tick_edges", n, 255);
    @(posedge clk); #1;
    measure(-1, 8'd0, 8'd0, hi, ticks);
    check("idle_duty", hi, 128);
    check("idle_ticks", ticks, 1);

    // Attack with full-scale wave
    keys = 8'h01;
    wave = 8'd255;
    b = -1;
    step_boundary();
    check("b0_active", int'(active), 1);
    check("b0_gain", int'(gain), 0);
    step_to(3);
    check("b3_gain", int'(gain), 0);
    step_to(4);
    check("b4_gain", int'(gain), 1);
    step_to(32);
    check("b32_gain", int'(gain), 8);
    wave = 8'd129;
    step_to(33);
    measure(-1, 8'd0, 8'd0, hi, ticks);
    check("duty_g8_w129", hi, 128);
    wave = 8'd127;
    step_to(35);
    measure(-1, 8'd0, 8'd0, hi, ticks);
    check("duty_g8_w127", hi, 127);
    check("b36_gain", int'(gain), 9);
    wave = 8'd255;
    step_to(63);
    check("b63_gain", int'(gain), 15);
    step_to(64);
    check("b64_gain", int'(gain), 16);
    check("b64_active", int'(active), 1);
    step_to(65);
    measure(-1, 8'd0, 8'd0, hi, ticks);
    check("duty_unity_w255", hi, 255);

    // Mid-period change of wave and release of keys
    measure(99, 8'd0, 8'd0, hi, ticks);
    check("duty_midchange", hi, 255);
    check("midchange_ticks", ticks, 1);
    check("b67_gain", int'(gain), 16);
    check("b67_active", int'(active), 1);
    measure(-1, 8'd0, 8'd0, hi, ticks);
    check("duty_unity_w0", hi, 0);
    check("w0_ticks", ticks, 1);

    // Release, then reversal at gain 10
    step_to(71);
    check("b71_gain", int'(gain), 15);
    step_to(91);
    check("b91_gain", int'(gain), 10);
    step_to(93);
    check("b93_gain", int'(gain), 10);
    keys = 8'h80;
    step_to(94);
    check("b94_gain", int'(gain), 10);
    check("b94_active", int'(active), 1);
    step_to(97);
    check("b97_gain", int'(gain), 10);
    step_to(98);
    check("b98_gain", int'(gain), 11);

    // Final release down to idle
    keys = 8'h00;
    step_to(99);
    check("b99_gain", int'(gain), 11);
    step_to(142);
    check("b142_gain", int'(gain), 1);
    check("b142_active", int'(active), 1);
    step_to(143);
    check("b143_gain", int'(gain), 0);
    check("b143_active", int'(active), 0);
    measure(-1, 8'd0, 8'd0, hi, ticks);
    check("duty_g1_w0", hi, 120);
    measure(-1, 8'd0, 8'd0, hi, ticks);
    check("duty_g0_w0", hi, 128);
    check("end_active", int'(active), 0);
    check("end_gain", int'(gain), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
